// File: rtl/register_scoreboard.sv
// Issue-stage register scoreboard: busy bits per GPR, FPR and FP condition flag.
// Optional macro SCOREBOARD_WB_BYPASS_EN lets a same-cycle writeback release a hazard.
module register_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int CNT_W    = 7
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        issue_valid,
   output logic                        issue_ready,
   input  logic [9:0]                  use_flags,
   input  logic [$clog2(NUM_REGS)-1:0] d_addr,
   input  logic [$clog2(NUM_REGS)-1:0] s_addr,
   input  logic [$clog2(NUM_REGS)-1:0] t_addr,
   input  logic                        wb0_valid,
   input  logic                        wb0_fpr,
   input  logic [$clog2(NUM_REGS)-1:0] wb0_addr,
   input  logic                        wb1_valid,
   input  logic                        wb1_fpr,
   input  logic                        wb1_fcond,
   input  logic [$clog2(NUM_REGS)-1:0] wb1_addr,
   output logic [CNT_W-1:0]            pending,
   output logic                        idle,
   output logic                        wb_err
);

   // Handshake: an instruction issues (fire) in any cycle where issue_valid and
   // issue_ready are both high; issue_ready never depends on issue_valid.

   logic [NUM_REGS-1:0] gpr_busy, fpr_busy;
   logic                fc_busy;
   logic [CNT_W-1:0]    pending_q;
   logic                wb_err_q;

   logic d_from_gpr, d_from_fpr, d_to_gpr, d_to_fpr;
   logic s_from_gpr, s_from_fpr, t_from_gpr, t_from_fpr;
   logic from_fcond, to_fcond;

   assign {d_from_gpr, d_from_fpr, d_to_gpr, d_to_fpr,
           s_from_gpr, s_from_fpr, t_from_gpr, t_from_fpr,
           from_fcond, to_fcond} = use_flags;

   // One-hot writeback targets; a GPR 0 writeback has no bit to clear and is ignored.
   logic [NUM_REGS-1:0] wb0_gpr_hit, wb0_fpr_hit, wb1_gpr_hit, wb1_fpr_hit;
   logic                wb1_fc_hit;

   always_comb begin
      wb0_gpr_hit = '0;
      wb0_fpr_hit = '0;
      wb1_gpr_hit = '0;
      wb1_fpr_hit = '0;
      wb1_fc_hit  = 1'b0;
      if (wb0_valid) begin
         if (wb0_fpr)
            wb0_fpr_hit[wb0_addr] = 1'b1;
         else if (wb0_addr != '0)
            wb0_gpr_hit[wb0_addr] = 1'b1;
      end
      if (wb1_valid) begin
         if (wb1_fcond)
            wb1_fc_hit = 1'b1;
         else if (wb1_fpr)
            wb1_fpr_hit[wb1_addr] = 1'b1;
         else if (wb1_addr != '0)
            wb1_gpr_hit[wb1_addr] = 1'b1;
      end
   end

   logic                wb0_tgt, wb1_tgt, wb0_tgt_busy, wb1_tgt_busy;
   logic                same_bit, eff0, eff1, err_now;
   logic [NUM_REGS-1:0] gpr_clr, fpr_clr;
   logic                fc_clr;

   assign wb0_tgt      = (|wb0_gpr_hit) | (|wb0_fpr_hit);
   assign wb1_tgt      = (|wb1_gpr_hit) | (|wb1_fpr_hit) | wb1_fc_hit;
   assign wb0_tgt_busy = |((wb0_gpr_hit & gpr_busy) | (wb0_fpr_hit & fpr_busy));
   assign wb1_tgt_busy = (|((wb1_gpr_hit & gpr_busy) | (wb1_fpr_hit & fpr_busy)))
                       | (wb1_fc_hit & fc_busy);
   assign same_bit     = |((wb0_gpr_hit & wb1_gpr_hit) | (wb0_fpr_hit & wb1_fpr_hit));

   // A double hit on one bit clears it once and counts once.
   assign eff0    = wb0_tgt & wb0_tgt_busy;
   assign eff1    = wb1_tgt & wb1_tgt_busy & ~same_bit;
   assign err_now = (wb0_tgt & ~wb0_tgt_busy) | (wb1_tgt & ~wb1_tgt_busy) | same_bit;

   assign gpr_clr = wb0_gpr_hit | wb1_gpr_hit;
   assign fpr_clr = wb0_fpr_hit | wb1_fpr_hit;
   assign fc_clr  = wb1_fc_hit;

   logic [NUM_REGS-1:0] gpr_view, fpr_view;
   logic                fc_view;

`ifdef SCOREBOARD_WB_BYPASS_EN
   assign gpr_view = gpr_busy & ~gpr_clr;
   assign fpr_view = fpr_busy & ~fpr_clr;
   assign fc_view  = fc_busy & ~fc_clr;
`else
   assign gpr_view = gpr_busy;
   assign fpr_view = fpr_busy;
   assign fc_view  = fc_busy;
`endif

   logic raw_hazard, waw_hazard, fire;

   assign raw_hazard = (d_from_gpr & gpr_view[d_addr]) | (d_from_fpr & fpr_view[d_addr])
                     | (s_from_gpr & gpr_view[s_addr]) | (s_from_fpr & fpr_view[s_addr])
                     | (t_from_gpr & gpr_view[t_addr]) | (t_from_fpr & fpr_view[t_addr])
                     | (from_fcond & fc_view);
   assign waw_hazard = (d_to_gpr & gpr_view[d_addr]) | (d_to_fpr & fpr_view[d_addr])
                     | (to_fcond & fc_view);

   assign issue_ready = ~(raw_hazard | waw_hazard);
   assign fire        = issue_valid & issue_ready;

   logic [NUM_REGS-1:0] gpr_set, fpr_set;
   logic                fc_set;

   always_comb begin
      gpr_set = '0;
      fpr_set = '0;
      fc_set  = 1'b0;
      if (fire) begin
         if (d_to_gpr && d_addr != '0) gpr_set[d_addr] = 1'b1;
         if (d_to_fpr)                 fpr_set[d_addr] = 1'b1;
         fc_set = to_fcond;
      end
   end

   // A set on a bit cleared in the same cycle nets to zero, keeping the bit busy.
   logic [CNT_W-1:0] n_set, n_clr;

   assign n_set = CNT_W'(|gpr_set) + CNT_W'(|fpr_set) + CNT_W'(fc_set);
   assign n_clr = CNT_W'(eff0) + CNT_W'(eff1);

   always_ff @(posedge clk) begin
      if (rst) begin
         gpr_busy  <= '0;
         fpr_busy  <= '0;
         fc_busy   <= 1'b0;
         pending_q <= '0;
         wb_err_q  <= 1'b0;
      end else begin
         gpr_busy  <= (gpr_busy & ~gpr_clr) | gpr_set;
         fpr_busy  <= (fpr_busy & ~fpr_clr) | fpr_set;
         fc_busy   <= (fc_busy & ~fc_clr) | fc_set;
         pending_q <= pending_q + n_set - n_clr;
         if (err_now)
            wb_err_q <= 1'b1;
      end
   end

   assign pending = pending_q;
   assign idle    = (pending_q == '0);
   assign wb_err  = wb_err_q;

endmodule

// File: tb/tb_register_scoreboard.sv
// Self-checking bench for register_scoreboard: directed scenarios with a pending-count queue.
module tb_register_scoreboard;

   localparam int NUM_REGS = 32;
   localparam int CNT_W    = 7;
`ifdef SCOREBOARD_WB_BYPASS_EN
   localparam logic BYPASS = 1'b1;
`else
   localparam logic BYPASS = 1'b0;
`endif

   localparam logic [9:0] D_FROM_GPR = 10'h200;
   localparam logic [9:0] D_TO_GPR   = 10'h080;
   localparam logic [9:0] D_TO_FPR   = 10'h040;
   localparam logic [9:0] S_FROM_GPR = 10'h020;
   localparam logic [9:0] S_FROM_FPR = 10'h010;
   localparam logic [9:0] T_FROM_GPR = 10'h008;
   localparam logic [9:0] FROM_FC    = 10'h002;
   localparam logic [9:0] TO_FC      = 10'h001;

   logic             clk = 1'b0;
   logic             rst;
   logic             issue_valid, issue_ready;
   logic [9:0]       use_flags;
   logic [4:0]       d_addr, s_addr, t_addr;
   logic             wb0_valid, wb0_fpr;
   logic [4:0]       wb0_addr;
   logic             wb1_valid, wb1_fpr, wb1_fcond;
   logic [4:0]       wb1_addr;
   logic [CNT_W-1:0] pending;
   logic             idle, wb_err;

   int               n_cmp = 0;
   int               n_bad = 0;
   logic [CNT_W-1:0] exp_q[$];
   logic [CNT_W-1:0] exp_v;

   register_scoreboard #(.NUM_REGS(NUM_REGS), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .use_flags(use_flags), .d_addr(d_addr), .s_addr(s_addr), .t_addr(t_addr),
      .wb0_valid(wb0_valid), .wb0_fpr(wb0_fpr), .wb0_addr(wb0_addr),
      .wb1_valid(wb1_valid), .wb1_fpr(wb1_fpr), .wb1_fcond(wb1_fcond), .wb1_addr(wb1_addr),
      .pending(pending), .idle(idle), .wb_err(wb_err)
   );

   // clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      issue_valid = 1'b0; use_flags = '0; d_addr = '0; s_addr = '0; t_addr = '0;
      wb0_valid = 1'b0; wb0_fpr = 1'b0; wb0_addr = '0;
      wb1_valid = 1'b0; wb1_fpr = 1'b0; wb1_fcond = 1'b0; wb1_addr = '0;
   endtask

   task automatic offer(input logic [9:0] f, input logic [4:0] d, input logic [4:0] s,
                        input logic [4:0] t);
      issue_valid = 1'b1; use_flags = f; d_addr = d; s_addr = s; t_addr = t;
   endtask

   task automatic drive_wb0(input logic fpr, input logic [4:0] a);
      wb0_valid = 1'b1; wb0_fpr = fpr; wb0_addr = a;
   endtask

   task automatic drive_wb1(input logic fpr, input logic fc, input logic [4:0] a);
      wb1_valid = 1'b1; wb1_fpr = fpr; wb1_fcond = fc; wb1_addr = a;
   endtask

   task automatic pulse_reset();
      clear_inputs();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   // scenarios
   task automatic test_reset();
      pulse_reset();
      exp_q.push_back(7'd0);
      exp_v = exp_q.pop_front(); n_cmp++;
      if (pending !== exp_v) begin n_bad++; $display("FAIL reset_pending: got %0d expected %0d", pending, exp_v); end
      n_cmp++;
      if (idle !== 1'b1) begin n_bad++; $display("FAIL reset_idle: got %b expected 1", idle); end
      n_cmp++;
      if (wb_err !== 1'b0) begin n_bad++; $display("FAIL reset_wb_err: got %b expected 0", wb_err); end
      for (int i = 0; i < 4; i++) begin
         offer(10'($urandom_range(0, 1023)), 5'($urandom_range(0, 31)),
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
         #1; n_cmp++;
         if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_rand%0d: got %b expected 1", i, issue_ready); end
      end
      clear_inputs();
      offer(D_TO_GPR, 5'd9, 5'd0, 5'd0); step();
      offer(TO_FC, 5'd0, 5'd0, 5'd0); step();
      clear_inputs();
      exp_q.push_back(7'd2);
      exp_v = exp_q.pop_front(); n_cmp++;
      if (pending !== exp_v) begin n_bad++; $display("FAIL prereset_pending: got %0d expected %0d", pending, exp_v); end
      pulse_reset();
      exp_q.push_back(7'd0);
      exp_v = exp_q.pop_front(); n_cmp++;
      if (pending !== exp_v) begin n_bad++; $display("FAIL midreset_pending: got %0d expected %0d", pending, exp_v); end
      n_cmp++;
      if (idle !== 1'b1) begin n_bad++; $display("FAIL midreset_idle: got %b expected 1", idle); end
      offer(S_FROM_GPR | FROM_FC | D_TO_GPR, 5'd9, 5'd9, 5'd0); #1; n_cmp++;
      if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL midreset_ready: got %b expected 1", issue_ready); end
      clear_inputs();
      drive_wb0(1'b0, 5'd12); step(); clear_inputs();
      n_cmp++;
      if (wb_err !== 1'b1) begin n_bad++; $display("FAIL stale_wb_err: got %b expected 1", wb_err); end
      exp_q.push_back(7'd0);
      exp_v = exp_q.pop_front(); n_cmp++;
      if (pending !== exp_v) begin n_bad++; $display("FAIL stale_wb_pending: got %0d expected %0d", pending, exp_v); end
      pulse_reset();
      n_cmp++;
      if (wb_err !== 1'b0) begin n_bad++; $display("FAIL err_cleared: got %b expected 0", wb_err); end
   endtask

   task automatic test_raw();
      offer(D_TO_GPR, 5'd5, 5'd0, 5'd0); #1; n_cmp++;
      if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL raw_first_ready: got %b expected 1", issue_ready); end
      step();
      exp_q.push_back(7'd1);
      offer(D_TO_GPR | S_FROM_GPR, 5'd6, 5'd5, 5'd0); #1; n_cmp++;
      if (issue_ready !== 1'b0) begin n_bad++; $display("FAIL raw_stall: got %b expected 0", issue_ready); end
      exp_v = exp_q.pop_front(); n_cmp++;
      if (pending !== exp_v) begin n_bad++; $display("FAIL raw_pending1: got %0d expected %0d", pending, exp_v); end
      step();
      drive_wb0(1'b0, 5'd5); #1; n_cmp++;
      if (issue_ready !== BYPASS) begin n_bad++; $display("FAIL raw_wb_cycle_ready: got %b expected %b", issue_ready, BYPASS); end
      step();
      wb0_valid = 1'b0; #1; n_cmp++;
      if (issue_ready !== !BYPASS) begin n_bad++; $display("FAIL raw_after_wb_ready: got %b expected %b", issue_ready, !BYPASS); end
      step(); clear_inputs();
      exp_q.push_back(7'd1);
      exp_v = exp_q.pop_front(); n_cmp++;
      if (pending !== exp_v) begin n_bad++; $display("FAIL raw_pending2: got %0d expected %0d", pending, exp_v); end
      drive_wb0(1'b0, 5'd6); step(); clear_inputs();
      exp_q.push_back(7'd0);
      exp_v = exp_q.pop_front(); n_cmp++;
      if (pending !== exp_v) begin n_bad++; $display("FAIL raw_drain: got %0d expected %0d", pending, exp_v); end
      n_cmp++;
      if (wb_err !== 1'b0) begin n_bad++; $display("FAIL raw_wb_err: got %b expected 0", wb_err); end
   endtask

   task automatic test_zero_reg();
      for (int i = 0; i < 2; i++) begin
         offer(D_TO_GPR | D_FROM_GPR | S_FROM_GPR | T_FROM_GPR, 5'd0, 5'd0, 5'd0); #1; n_cmp++;
         if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL zero_ready%0d: got %b expected 1", i, issue_ready); end
         step();
      end
      clear_inputs();
      exp_q.push_back(7'd0);
      exp_v = exp_q.pop_front(); n_cmp++;
      if (pending !== exp_v) begin n_bad++; $display("FAIL zero_pending: got %0d expected %0d", pending, exp_v); end
      n_cmp++;
      if (idle !== 1'b1) begin n_bad++; $display("FAIL zero_idle: got %b expected 1", idle); end
      offer(D_TO_FPR, 5'd0, 5'd0, 5'd0); step();
      offer(S_FROM_FPR, 5'd0, 5'd0, 5'd0); #1; n_cmp++;
      if (issue_ready !== 1'b0) begin n_bad++; $display("FAIL fpr0_stall: got %b expected 0", issue_ready); end
      step(); clear_inputs();
      exp_q.push_back(7'd1);
      exp_v = exp_q.pop_front(); n_cmp++;
      if (pending !== exp_v) begin n_bad++; $display("FAIL fpr0_pending: got %0d expected %0d", pending, exp_v); end
      drive_wb0(1'b1, 5'd0); step(); clear_inputs();
      exp_q.push_back(7'd0);
      exp_v = exp_q.pop_front(); n_cmp++;
      if (pending !== exp_v) begin n_bad++; $display("FAIL fpr0_drain: got %0d expected %0d", pending, exp_v); end
   endtask

   task automatic test_fcond();
      offer(TO_FC, 5'd0, 5'd0, 5'd0); step();
      offer(FROM_FC, 5'd0, 5'd0, 5'd0); #1; n_cmp++;
      if (issue_ready !== 1'b0) begin n_bad++; $display("FAIL fc_stall: got %b expected 0", issue_ready); end
      step();
      drive_wb1(1'b1, 1'b1, 5'd3); #1; n_cmp++;
      if (issue_ready !== BYPASS) begin n_bad++; $display("FAIL fc_wb_cycle_ready: got %b expected %b", issue_ready, BYPASS); end
      step();
      wb1_valid = 1'b0; #1; n_cmp++;
      if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL fc_after_wb_ready: got %b expected 1", issue_ready); end
      step(); clear_inputs();
      exp_q.push_back(7'd0);
      exp_v = exp_q.pop_front(); n_cmp++;
      if (pending !== exp_v) begin n_bad++; $display("FAIL fc_pending: got %0d expected %0d", pending, exp_v); end
      n_cmp++;
      if (wb_err !== 1'b0) begin n_bad++; $display("FAIL fc_wb_err: got %b expected 0", wb_err); end
      offer(TO_FC, 5'd0, 5'd0, 5'd0); step();
      drive_wb1(1'b0, 1'b1, 5'd0); #1; n_cmp++;
      if (issue_ready !== BYPASS) begin n_bad++; $display("FAIL fc_same_cycle_ready: got %b expected %b", issue_ready, BYPASS); end
      step();
      exp_q.push_back(CNT_W'(BYPASS));
      exp_v = exp_q.pop_front(); n_cmp++;
      if (pending !== exp_v) begin n_bad++; $display("FAIL fc_same_cycle_pending: got %0d expected %0d", pending, exp_v); end
      wb1_valid = 1'b0; #1; n_cmp++;
      if (issue_ready !== !BYPASS) begin n_bad++; $display("FAIL fc_set_wins_ready: got %b expected %b", issue_ready, !BYPASS); end
      step();
      offer(FROM_FC, 5'd0, 5'd0, 5'd0); #1; n_cmp++;
      if (issue_ready !== 1'b0) begin n_bad++; $display("FAIL fc_still_busy: got %b expected 0", issue_ready); end
      exp_q.push_back(7'd1);
      exp_v = exp_q.pop_front(); n_cmp++;
      if (pending !== exp_v) begin n_bad++; $display("FAIL fc_busy_pending: got %0d expected %0d", pending, exp_v); end
      clear_inputs();
      drive_wb1(1'b0, 1'b1, 5'd0); step(); clear_inputs();
      exp_q.push_back(7'd0);
      exp_v = exp_q.pop_front(); n_cmp++;
      if (pending !== exp_v) begin n_bad++; $display("FAIL fc_drain: got %0d expected %0d", pending, exp_v); end
      n_cmp++;
      if (wb_err !== 1'b0) begin n_bad++; $display("FAIL fc_drain_wb_err: got %b expected 0", wb_err); end
   endtask

   task automatic test_waw_double_wb();
      offer(D_TO_FPR, 5'd3, 5'd0, 5'd0); step();
      offer(D_TO_GPR, 5'd10, 5'd0, 5'd0); step();
      offer(D_TO_FPR, 5'd3, 5'd0, 5'd0); #1; n_cmp++;
      if (issue_ready !== 1'b0) begin n_bad++; $display("FAIL waw_stall: got %b expected 0", issue_ready); end
      step(); clear_inputs();
      exp_q.push_back(7'd2);
      exp_v = exp_q.pop_front(); n_cmp++;
      if (pending !== exp_v) begin n_bad++; $display("FAIL waw_pending: got %0d expected %0d", pending, exp_v); end
      drive_wb0(1'b1, 5'd3); drive_wb1(1'b1, 1'b0, 5'd3); step(); clear_inputs();
      exp_q.push_back(7'd1);
      exp_v = exp_q.pop_front(); n_cmp++;
      if (pending !== exp_v) begin n_bad++; $display("FAIL dbl_wb_pending: got %0d expected %0d", pending, exp_v); end
      n_cmp++;
      if (wb_err !== 1'b1) begin n_bad++; $display("FAIL dbl_wb_err: got %b expected 1", wb_err); end
      offer(S_FROM_FPR | D_TO_FPR, 5'd3, 5'd3, 5'd0); #1; n_cmp++;
      if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL dbl_wb_freed: got %b expected 1", issue_ready); end
      clear_inputs();
      drive_wb0(1'b0, 5'd10); step(); clear_inputs();
      n_cmp++;
      if (idle !== 1'b1) begin n_bad++; $display("FAIL dbl_wb_idle: got %b expected 1", idle); end
      pulse_reset();
   endtask

   task automatic test_back_to_back();
      int cnt;
      int order[32];
      cnt = 0;
      for (int i = 1; i < NUM_REGS; i++) begin
         offer(D_TO_GPR, 5'(i), 5'd0, 5'd0); #1; n_cmp++;
         if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_gpr_ready%0d: got %b expected 1", i, issue_ready); end
         step(); cnt++;
         exp_q.push_back(CNT_W'(cnt));
         exp_v = exp_q.pop_front(); n_cmp++;
         if (pending !== exp_v) begin n_bad++; $display("FAIL b2b_gpr_pending%0d: got %0d expected %0d", i, pending, exp_v); end
      end
      for (int i = 0; i < NUM_REGS; i++) begin
         offer(D_TO_FPR, 5'(i), 5'd0, 5'd0); step(); cnt++;
         exp_q.push_back(CNT_W'(cnt));
         exp_v = exp_q.pop_front(); n_cmp++;
         if (pending !== exp_v) begin n_bad++; $display("FAIL b2b_fpr_pending%0d: got %0d expected %0d", i, pending, exp_v); end
      end
      offer(TO_FC, 5'd0, 5'd0, 5'd0); step(); clear_inputs(); cnt++;
      exp_q.push_back(7'd64);
      exp_v = exp_q.pop_front(); n_cmp++;
      if (pending !== exp_v) begin n_bad++; $display("FAIL b2b_full_pending: got %0d expected %0d", pending, exp_v); end
      n_cmp++;
      if (idle !== 1'b0) begin n_bad++; $display("FAIL b2b_full_idle: got %b expected 0", idle); end
      for (int i = 0; i < 32; i++) order[i] = i;
      for (int i = 31; i > 0; i--) begin
         int j, tmp;
         j = $urandom_range(0, i);
         tmp = order[i]; order[i] = order[j]; order[j] = tmp;
      end
      for (int i = 0; i < 32; i++) begin
         clear_inputs();
         drive_wb1(1'b1, 1'b0, 5'(order[i]));
         if (order[i] != 0) drive_wb0(1'b0, 5'(order[i]));
         step();
         cnt = cnt - ((order[i] != 0) ? 2 : 1);
         exp_q.push_back(CNT_W'(cnt));
         exp_v = exp_q.pop_front(); n_cmp++;
         if (pending !== exp_v) begin n_bad++; $display("FAIL b2b_retire_pending%0d: got %0d expected %0d", order[i], pending, exp_v); end
      end
      clear_inputs();
      drive_wb1(1'b0, 1'b1, 5'd0); step(); clear_inputs();
      exp_q.push_back(7'd0);
      exp_v = exp_q.pop_front(); n_cmp++;
      if (pending !== exp_v) begin n_bad++; $display("FAIL b2b_empty_pending: got %0d expected %0d", pending, exp_v); end
      n_cmp++;
      if (idle !== 1'b1) begin n_bad++; $display("FAIL b2b_empty_idle: got %b expected 1", idle); end
      n_cmp++;
      if (wb_err !== 1'b0) begin n_bad++; $display("FAIL b2b_wb_err: got %b expected 0", wb_err); end
   endtask

   // sequence and final report
   initial begin
      clear_inputs();
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      test_reset();
      test_raw();
      test_zero_reg();
      test_fcond();
      test_waw_double_wb();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
